mem_access_ctrl: RTL

Memory-access sequencer between the CPU register block and the external memory bus. It takes the address from mar_q and write data from mdr_q, and runs one read or write bus cycle with an ack/timeout handshake. Read data returns on mmd_out (the MDR load path) or mis_out (the ISR load path). It is the producer of the MMD_out/MIS_out inputs of the register block and the consumer of its mar_q/mdr_q/isr_q outputs.

---
 rtl/mem_access_ctrl_pkg.sv | 18 +
 rtl/mem_wait_timer.sv | 32 +++
 rtl/mem_access_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Purpose: shared state encoding and default sizes for the memory-access sequencer.
// Contents: state_t (IDLE/RD/WR/DONE/ABORT, 3 bits), DW/TIMEOUT/TW defaults.
// No ports; imported by mem_access_ctrl and mem_wait_timer.
package mem_access_ctrl_pkg;

   localparam int DW_DEF      = 16;
   localparam int TIMEOUT_DEF = 15;
   localparam int TW_DEF      = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD    = 3'd1,
      S_WR    = 3'd2,
      S_DONE  = 3'd3,
      S_ABORT = 3'd4
   } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Purpose: counts bus-cycle wait states and flags when the ack window has expired.
// Ports: clk/clr (async active-high), run (access in progress), load0 (access starting),
//        expired (count has reached TIMEOUT).
module mem_wait_timer
   import mem_access_ctrl_pkg::*;
#(
   parameter int TW      = TW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic clr,
   input  logic run,
   input  logic load0,
   output logic expired
);

   logic [TW-1:0] cnt_q;

   // Held at zero outside an access so every access starts from a clean count.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt_q <= '0;
      end else if (load0 || !run) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + TW'(1);
      end
   end

   assign expired = (cnt_q == TW'(TIMEOUT));

endmodule

// File: rtl/mem_access_ctrl.sv
// Purpose: runs one read or write bus cycle per request from MAR/MDR, with ack/timeout.
// Ports: rd_req/wr_req/ifetch request; mar_q/mdr_q/isr_q from the register block;
//        mem_* bus side; mmd_out/mis_out load values back; busy/done/err status, err_clr.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TW      = TW_DEF
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          rd_req,
   input  logic          wr_req,
   input  logic          ifetch,
   input  logic [DW-1:0] mar_q,
   input  logic [DW-1:0] mdr_q,
   input  logic [DW-1:0] isr_q,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_re,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic [DW-1:0] mmd_out,
   output logic [DW-1:0] mis_out,
   output logic          busy,
   output logic          done,
   output logic          err,
   input  logic          err_clr
);

   state_t        state_q;
   logic [DW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rdata_q;
   logic          tgt_q;     // 1: read result goes to ISR, 0: to MDR
   logic          is_rd_q;   // current/finished access was a read
   logic          err_q;
   logic          expired;
   logic          run;
   logic          load0;
   logic          rd_fill;

   assign run   = (state_q == S_RD) || (state_q == S_WR);
   assign load0 = (state_q == S_IDLE) && (rd_req ^ wr_req);

   mem_wait_timer #(
      .TW      (TW),
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .clr     (clr),
      .run     (run),
      .load0   (load0),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         tgt_q   <= 1'b0;
         is_rd_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         // A set later in this block overrides the clear, so a new abort wins.
         if (err_clr) begin
            err_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (rd_req && wr_req) begin
                  state_q <= S_ABORT;
                  is_rd_q <= 1'b0;
                  err_q   <= 1'b1;
               end else if (rd_req) begin
                  state_q <= S_RD;
                  addr_q  <= mar_q;
                  tgt_q   <= ifetch;
                  is_rd_q <= 1'b1;
               end else if (wr_req) begin
                  state_q <= S_WR;
                  addr_q  <= mar_q;
                  wdata_q <= mdr_q;
                  is_rd_q <= 1'b0;
               end
            end
            S_RD, S_WR: begin
               // Ack is checked first so a last-moment ack still completes.
               if (mem_ack) begin
                  state_q <= S_DONE;
                  if (state_q == S_RD) begin
                     rdata_q <= mem_rdata;
                  end
               end else if (expired) begin
                  state_q <= S_ABORT;
                  err_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign rd_fill   = (state_q == S_DONE) && is_rd_q;
   assign mem_re    = (state_q == S_RD);
   assign mem_we    = (state_q == S_WR);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE) || (state_q == S_ABORT);
   assign err       = err_q;
   // mmd_out is ORed downstream, so it must be exactly zero when not loading.
   assign mmd_out   = (rd_fill && !tgt_q) ? rdata_q : '0;
   assign mis_out   = (rd_fill &&  tgt_q) ? rdata_q : isr_q;

endmodule
